// File: rtl/interval_timer_mc_pkg.sv
// Shared constants for the multi-channel interval timer:
// register offsets, control/status bit indices, address width helper.
package interval_timer_mc_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD_L = 3'd2;
  localparam logic [2:0] OFF_PERIOD_H = 3'd3;
  localparam logic [2:0] OFF_SNAP_L   = 3'd4;
  localparam logic [2:0] OFF_SNAP_H   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // {channel, offset} word address width
  function automatic int addr_w(input int n);
    return 3 + ((n > 1) ? $clog2(n) : 0);
  endfunction

endpackage

// File: rtl/interval_timer_channel.sv
// One timer channel: period/prescale/control regs, prescaler, counter,
// RUN/TO logic, snapshot. Ports: clk, reset_n, wr_i (per-offset strobes),
// wdata_i, rd_off_i -> rd_data_o (combinational), irq_o.
module interval_timer_channel
  import interval_timer_mc_pkg::*;
#(
  parameter int unsigned COUNTER_W      = 32,
  parameter int unsigned PRESCALE_W     = 8,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  wr_i,
  input  logic [15:0] wdata_i,
  input  logic [2:0]  rd_off_i,
  output logic [15:0] rd_data_o,
  output logic        irq_o
);

  localparam int CW = COUNTER_W;
  localparam int PW = PRESCALE_W;
  localparam logic [CW-1:0] RST_PER = CW'(DEFAULT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PS_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic          RST_ZD  = (DEFAULT_PERIOD == 0);

  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] snap_q, snap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic          run_q, run_d;
  logic          to_q, to_d;
  logic          zdly_q, zdly_d;
  logic          force_q, force_d;

  logic zero, tick, start, stop, cont, to_ev;

  assign zero  = (cnt_q == '0);
  assign tick  = run_q && (pcnt_q == '0);
  assign start = wr_i[OFF_CONTROL] && wdata_i[CTRL_START];
  assign stop  = wr_i[OFF_CONTROL] && wdata_i[CTRL_STOP];
  assign cont  = ctrl_q[CTRL_CONT];
  // rising edge of the zero flag; a parked zero fires once
  assign to_ev = zero && !zdly_q;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    ctrl_d   = ctrl_q;
    run_d    = run_q;
    to_d     = to_q;
    zdly_d   = zero;
    force_d  = wr_i[OFF_PERIOD_L] || wr_i[OFF_PERIOD_H];

    if (wr_i[OFF_PERIOD_L]) period_d[15:0] = wdata_i;
    if (wr_i[OFF_PERIOD_H]) period_d[CW-1:16] = wdata_i[CW-17:0];
    if (wr_i[OFF_PRESCALE]) presc_d = wdata_i[PW-1:0];
    if (wr_i[OFF_CONTROL])  ctrl_d = wdata_i[3:0];
    if (wr_i[OFF_SNAP_L] || wr_i[OFF_SNAP_H]) snap_d = cnt_q;

    if (force_q)     pcnt_d = '0;
    else if (tick)   pcnt_d = presc_q;
    else if (run_q)  pcnt_d = pcnt_q - PS_ONE;

    if (force_q) begin
      cnt_d = period_q;
    end else if (tick) begin
      if (!zero)     cnt_d = cnt_q - CNT_ONE;
      else if (cont) cnt_d = period_q;
    end

    if (start)               run_d = 1'b1;
    else if (stop)           run_d = 1'b0;
    else if (force_q)        run_d = 1'b0;
    else if (zero && !cont)  run_d = 1'b0;

    if (wr_i[OFF_STATUS]) to_d = 1'b0;
    else if (to_ev)       to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_q <= RST_PER;
      cnt_q    <= RST_PER;
      snap_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      ctrl_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      zdly_q   <= RST_ZD;
      force_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      ctrl_q   <= ctrl_d;
      run_q    <= run_d;
      to_q     <= to_d;
      zdly_q   <= zdly_d;
      force_q  <= force_d;
    end
  end

  logic [31:0] per_ext, snap_ext;
  assign per_ext  = 32'(period_q);
  assign snap_ext = 32'(snap_q);

  always_comb begin
    rd_data_o = '0;
    case (rd_off_i)
      OFF_STATUS:   rd_data_o = {14'd0, run_q, to_q};
      OFF_CONTROL:  rd_data_o = {12'd0, ctrl_q};
      OFF_PERIOD_L: rd_data_o = per_ext[15:0];
      OFF_PERIOD_H: rd_data_o = per_ext[31:16];
      OFF_SNAP_L:   rd_data_o = snap_ext[15:0];
      OFF_SNAP_H:   rd_data_o = snap_ext[31:16];
      OFF_PRESCALE: rd_data_o = 16'(presc_q);
      default:      rd_data_o = '0;
    endcase
  end

  assign irq_o = to_q && ctrl_q[CTRL_ITO];

endmodule

// File: rtl/interval_timer_mc.sv
// Multi-channel Avalon-MM interval timer top: channel decode, channel
// array, registered readdata mux, OR-ed level irq.
module interval_timer_mc
  import interval_timer_mc_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned COUNTER_W      = 32,
  parameter int unsigned PRESCALE_W     = 8,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [addr_w(NUM_CH)-1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [15:0]                 writedata,
  output logic [15:0]                 readdata,
  output logic                        irq
);

  localparam int AW = addr_w(NUM_CH);
  localparam int SW = (NUM_CH > 1) ? AW - 3 : 1;

  logic [SW-1:0]     ch_sel;
  logic [6:0]        off_dec;
  logic              wr_en;
  logic [15:0]       rd_ch [NUM_CH];
  logic [NUM_CH-1:0] irq_ch;
  logic [15:0]       rd_d, rd_q;

  if (NUM_CH > 1) begin : g_sel
    assign ch_sel = address[AW-1:3];
  end else begin : g_sel1
    assign ch_sel = '0;
  end

  assign wr_en   = chipselect && !write_n;
  // offset 7 shifts out, so reserved writes reach no register
  assign off_dec = 7'b1 << address[2:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [6:0] wr;
    assign wr = (wr_en && ch_sel == SW'(c)) ? off_dec : '0;

    interval_timer_channel #(
      .COUNTER_W      (COUNTER_W),
      .PRESCALE_W     (PRESCALE_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_i      (wr),
      .wdata_i   (writedata),
      .rd_off_i  (address[2:0]),
      .rd_data_o (rd_ch[c]),
      .irq_o     (irq_ch[c])
    );
  end

  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == SW'(c)) rd_d = rd_ch[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign readdata = rd_q;
  assign irq      = |irq_ch;

endmodule
